i2c_target: RTL and testbench
=============================

I2C_TARGET -- requirements
Module: i2c_target

Interface
REQ-001 Parameter DEVICE_ADDR, default 7'h50: 7-bit I2C address the block answers to.
REQ-002 Parameter FILTER_LEN, default 4: number of clk cycles an input level must hold to be accepted (used only with I2C_TARGET_FILTER_EN).
REQ-003 clk  in  1  system clock, 32 MHz domain.
REQ-004 reset_n  in  1  reset, asynchronous and active-low.
REQ-005 scl_i  in  1  SCL pad level, asynchronous.
REQ-006 sda_i  in  1  SDA pad level, asynchronous.
REQ-007 sda_enable  out  1  when 1, SDA is driven low; when 0, SDA is released (open-drain).
REQ-008 reg_addr  out  8  register pointer presented to the register bank.
REQ-009 wr_data  out  8  received data byte, valid while wr_strobe is 1.
REQ-010 wr_strobe  out  1  one-cycle pulse that writes wr_data at reg_addr.
REQ-011 rd_data  in  8  register contents at reg_addr, sampled exactly 1 cycle after rd_strobe.
REQ-012 rd_strobe  out  1  one-cycle pulse that requests a read of reg_addr.
REQ-013 busy  out  1  1 from START detect until STOP detect.

Function
REQ-014 scl_i and sda_i shall pass through 2-FF synchronizers; all edge and condition detection shall use the synchronized levels.
REQ-015 START (SDA falling while SCL high) and STOP (SDA rising while SCL high) shall be detected in any state and take priority over bit processing.
REQ-016 The states shall be IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WRITE, WRITE_ACK, READ, READ_ACK and WAIT.
REQ-017 START shall move to ADDR from any state, including a repeated START; reg_addr shall be retained.
REQ-018 STOP shall move to IDLE, clear busy and release sda_enable in the same cycle.
REQ-019 Bits shall be sampled on SCL rising edges, MSB first; 8 bits shall complete a byte.
REQ-020 sda_enable shall change only in the cycle after a detected SCL falling edge.
REQ-021 Address byte matches DEVICE_ADDR with R/W=0: ACK, then PTR.
REQ-022 Address byte matches DEVICE_ADDR with R/W=1: ACK, then READ.
REQ-023 Address byte does not match: no ACK, then WAIT; WAIT exits only on START or STOP.
REQ-024 ACK shall assert sda_enable at the SCL falling edge after bit 8 and release it at the next SCL falling edge.
REQ-025 PTR byte: load reg_addr, ACK, then WRITE.
REQ-026 WRITE byte: pulse wr_strobe for one cycle with the current reg_addr, ACK, then increment reg_addr.
REQ-027 READ: pulse rd_strobe at the SCL falling edge that ends the address ACK or the master ACK; capture rd_data 1 cycle later into the shift register.
REQ-028 READ: drive sda_enable = ~bit on each SCL falling edge; increment reg_addr after the 8th bit.
REQ-029 READ_ACK: sample the master bit; 0 (ACK) returns to READ; 1 (NACK) goes to WAIT with SDA released.
REQ-030 reg_addr shall wrap 8'hFF -> 8'h00 on increment.
REQ-031 The block shall never stretch SCL.

Reset
REQ-032 With reset_n low: state IDLE; sda_enable, wr_strobe, rd_strobe and busy 0; reg_addr and wr_data 8'h00; synchronizers and filters set to 1 (bus idle).
REQ-033 Reset asserted mid-transfer shall release SDA combinationally-free, i.e. directly from the asynchronous flop clear, with no clock edge required.

Configuration
REQ-034 Macro I2C_TARGET_FILTER_EN defined: each synchronized input shall update only after FILTER_LEN consecutive equal samples, rejecting shorter glitches.
REQ-035 Macro I2C_TARGET_FILTER_EN undefined: the 2-FF synchronizer outputs shall be used directly, with no filter logic.

Verification
REQ-036 Write transfer: START, 0xA0, 0x10, 0xAB, 0xCD, STOP -> 4 ACKs; wr_strobe at reg_addr 0x10 with data 0xAB, then at 0x11 with 0xCD; final reg_addr 0x12.
REQ-037 Read transfer: START, 0xA0, 0x20, repeated START, 0xA1, read 2 bytes (master ACK, then NACK), STOP, with the bank returning 0x5A and 0xC3 -> SDA bytes 0x5A, 0xC3; rd_strobe at 0x20 and 0x21; SDA released after the NACK.
REQ-038 Address mismatch: START, 0xA2, then 0x55 -> sda_enable stays 0 and no strobes; the next START with 0xA0 is ACKed.
REQ-039 Wrap-around: pointer 0xFF, write 2 bytes -> wr_strobe at 0xFF, then at 0x00.
REQ-040 Reset mid-read while driving a 0 bit -> sda_enable 0 immediately, busy 0; a following START with 0xA0 is ACKed.
REQ-041 Glitch rejection: 2-cycle SCL low pulse during a byte -> with I2C_TARGET_FILTER_EN (FILTER_LEN=4), no bit is counted and the byte is received correctly.

Source files
------------

// File: rtl/i2c_target.sv
// i2c_target: I2C target with an 8-bit register pointer, byte writes and
// auto-incrementing reads against an external register bank. SCL is never stretched.
// Optional input glitch filter: define I2C_TARGET_FILTER_EN.
//
// state     | meaning
// IDLE      | bus free, waiting for START
// ADDR      | shifting in address byte + R/W
// ADDR_ACK  | acknowledging our address
// PTR       | shifting in register pointer
// PTR_ACK   | acknowledging pointer byte
// WRITE     | shifting in a data byte
// WRITE_ACK | acknowledging data byte, pointer advances at release
// READ      | driving a data byte onto SDA
// READ_ACK  | sampling master ACK/NACK
// WAIT      | not addressed / read finished, waiting for START or STOP
module i2c_target #(
    parameter logic [6:0]  DEVICE_ADDR = 7'h50,
    parameter int unsigned FILTER_LEN  = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_enable,
    output logic [7:0] reg_addr,
    output logic [7:0] wr_data,
    output logic       wr_strobe,
    input  logic [7:0] rd_data,
    output logic       rd_strobe,
    output logic       busy
);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, WAIT
    } state_t;

    logic scl_s1_q, scl_s2_q, sda_s1_q, sda_s2_q;
    logic scl_f, sda_f;
    logic scl_prev_q, sda_prev_q;
    logic scl_rise, scl_fall, start_det, stop_det;

    state_t     state_q;
    logic [2:0] bit_cnt_q;
    logic [7:0] shift_q;
    logic [7:0] reg_addr_q;
    logic [7:0] wr_data_q;
    logic       wr_strobe_q, rd_strobe_q, busy_q, sda_en_q, rw_q, nack_q;
    logic [7:0] byte_in;

    // Two-flop synchronizers on the asynchronous pad levels; reset to bus idle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scl_s1_q <= 1'b1;
            scl_s2_q <= 1'b1;
            sda_s1_q <= 1'b1;
            sda_s2_q <= 1'b1;
        end else begin
            scl_s1_q <= scl_i;
            scl_s2_q <= scl_s1_q;
            sda_s1_q <= sda_i;
            sda_s2_q <= sda_s1_q;
        end
    end

`ifdef I2C_TARGET_FILTER_EN
    localparam int unsigned FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [FW-1:0] FLT_RELOAD = FW'(FILTER_LEN - 1);

    logic          scl_flt_q, sda_flt_q;
    logic [FW-1:0] scl_cnt_q, sda_cnt_q;

    // Accept a new level only after FILTER_LEN consecutive samples differ from the held one.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scl_flt_q <= 1'b1;
            sda_flt_q <= 1'b1;
            scl_cnt_q <= FLT_RELOAD;
            sda_cnt_q <= FLT_RELOAD;
        end else begin
            if (scl_s2_q == scl_flt_q) begin
                scl_cnt_q <= FLT_RELOAD;
            end else if (scl_cnt_q == '0) begin
                scl_flt_q <= scl_s2_q;
                scl_cnt_q <= FLT_RELOAD;
            end else begin
                scl_cnt_q <= scl_cnt_q - FW'(1);
            end
            if (sda_s2_q == sda_flt_q) begin
                sda_cnt_q <= FLT_RELOAD;
            end else if (sda_cnt_q == '0) begin
                sda_flt_q <= sda_s2_q;
                sda_cnt_q <= FLT_RELOAD;
            end else begin
                sda_cnt_q <= sda_cnt_q - FW'(1);
            end
        end
    end

    assign scl_f = scl_flt_q;
    assign sda_f = sda_flt_q;
`else
    // FILTER_LEN has no effect in the unfiltered build.
    logic unused_filter_len;
    assign unused_filter_len = ^FILTER_LEN;
    assign scl_f = scl_s2_q;
    assign sda_f = sda_s2_q;
`endif

    // Previous accepted levels for edge and START/STOP detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_prev_q <= scl_f;
            sda_prev_q <= sda_f;
        end
    end

    assign scl_rise  = scl_f & ~scl_prev_q;
    assign scl_fall  = ~scl_f & scl_prev_q;
    assign start_det = scl_f & scl_prev_q & sda_prev_q & ~sda_f;
    assign stop_det  = scl_f & scl_prev_q & ~sda_prev_q & sda_f;
    assign byte_in   = {shift_q[6:0], sda_f};

    // Protocol FSM; bus conditions override bit processing in every state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            reg_addr_q  <= 8'h00;
            wr_data_q   <= 8'h00;
            wr_strobe_q <= 1'b0;
            rd_strobe_q <= 1'b0;
            busy_q      <= 1'b0;
            sda_en_q    <= 1'b0;
            rw_q        <= 1'b0;
            nack_q      <= 1'b1;
        end else begin
            wr_strobe_q <= 1'b0;
            rd_strobe_q <= 1'b0;
            if (start_det) begin
                state_q   <= ADDR;
                busy_q    <= 1'b1;
                bit_cnt_q <= 3'd0;
            end else if (stop_det) begin
                state_q   <= IDLE;
                busy_q    <= 1'b0;
                sda_en_q  <= 1'b0;
                bit_cnt_q <= 3'd0;
            end else begin
                // Bank data arrives the cycle after the read request; shift_q keeps
                // the remaining bits with the next one to drive in bit 7.
                if (rd_strobe_q) begin
                    shift_q  <= {rd_data[6:0], 1'b1};
                    sda_en_q <= ~rd_data[7];
                end
                case (state_q)
                    ADDR, PTR, WRITE: begin
                        if (scl_rise) begin
                            shift_q   <= byte_in;
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                if (state_q == ADDR) begin
                                    if (byte_in[7:1] == DEVICE_ADDR) begin
                                        rw_q    <= byte_in[0];
                                        state_q <= ADDR_ACK;
                                    end else begin
                                        state_q <= WAIT;
                                    end
                                end else if (state_q == PTR) begin
                                    reg_addr_q <= byte_in;
                                    state_q    <= PTR_ACK;
                                end else begin
                                    wr_data_q   <= byte_in;
                                    wr_strobe_q <= 1'b1;
                                    state_q     <= WRITE_ACK;
                                end
                            end
                        end
                    end
                    ADDR_ACK, PTR_ACK, WRITE_ACK: begin
                        // First falling edge drives the ACK, the next one releases it.
                        if (scl_fall) begin
                            if (!sda_en_q) begin
                                sda_en_q <= 1'b1;
                            end else begin
                                sda_en_q <= 1'b0;
                                if (state_q == ADDR_ACK) begin
                                    if (rw_q) begin
                                        rd_strobe_q <= 1'b1;
                                        state_q     <= READ;
                                    end else begin
                                        state_q <= PTR;
                                    end
                                end else if (state_q == PTR_ACK) begin
                                    state_q <= WRITE;
                                end else begin
                                    reg_addr_q <= reg_addr_q + 8'd1;
                                    state_q    <= WRITE;
                                end
                            end
                        end
                    end
                    READ: begin
                        if (scl_rise) begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                reg_addr_q <= reg_addr_q + 8'd1;
                            end
                        end else if (scl_fall) begin
                            if (bit_cnt_q == 3'd0) begin
                                sda_en_q <= 1'b0;
                                state_q  <= READ_ACK;
                            end else begin
                                sda_en_q <= ~shift_q[7];
                                shift_q  <= {shift_q[6:0], 1'b1};
                            end
                        end
                    end
                    READ_ACK: begin
                        if (scl_rise) begin
                            nack_q <= sda_f;
                        end else if (scl_fall) begin
                            if (!nack_q) begin
                                rd_strobe_q <= 1'b1;
                                state_q     <= READ;
                            end else begin
                                state_q <= WAIT;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign sda_enable = sda_en_q;
    assign reg_addr   = reg_addr_q;
    assign wr_data    = wr_data_q;
    assign wr_strobe  = wr_strobe_q;
    assign rd_strobe  = rd_strobe_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_i2c_target.sv
// tb_i2c_target: bit-banged I2C master against i2c_target with a small register
// bank model; strobes are checked by a scoreboard monitor, bus responses inline.
module tb_i2c_target;
    localparam int Q = 16;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       glitch = 1'b0;
    logic       scl_i, sda_i, sda_enable, wr_strobe, rd_strobe, busy;
    logic [7:0] reg_addr, wr_data, rd_data;
    logic [7:0] mem [256];

    int         checks = 0;
    int         errors = 0;
    int         sda_hi_cnt = 0;
    logic [15:0] exp_wr [$];
    logic [7:0]  exp_rd [$];

    always #5 clk = ~clk;

    assign scl_i   = scl_m & ~glitch;
    assign sda_i   = sda_m & ~sda_enable;
    assign rd_data = mem[reg_addr];

    i2c_target #(.DEVICE_ADDR(7'h50), .FILTER_LEN(4)) dut (
        .clk(clk), .reset_n(reset_n), .scl_i(scl_i), .sda_i(sda_i),
        .sda_enable(sda_enable), .reg_addr(reg_addr), .wr_data(wr_data),
        .wr_strobe(wr_strobe), .rd_data(rd_data), .rd_strobe(rd_strobe), .busy(busy)
    );

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Scoreboard monitor: every strobe pops the next expected entry.
    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            if (sda_enable === 1'b1) sda_hi_cnt++;
            if (wr_strobe === 1'b1) begin
                if (exp_wr.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL wr_strobe_unexpected: got addr %h data %h expected none", reg_addr, wr_data);
                end else begin
                    chk("wr_strobe addr/data", {reg_addr, wr_data}, exp_wr.pop_front());
                end
            end
            if (rd_strobe === 1'b1) begin
                if (exp_rd.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rd_strobe_unexpected: got addr %h expected none", reg_addr);
                end else begin
                    chk("rd_strobe addr", 16'(reg_addr), 16'(exp_rd.pop_front()));
                end
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        sda_m = 1'b0; wait_clk(Q);
        scl_m = 1'b0; wait_clk(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        sda_m = 1'b1; wait_clk(Q);
    endtask

    task automatic bit_cycle(input logic b, input logic glitch_en, output logic smp);
        sda_m = b; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q/2);
        if (glitch_en) begin
            glitch = 1'b1; wait_clk(2);
            glitch = 1'b0; wait_clk(Q/2 - 2);
        end else begin
            wait_clk(Q/2);
        end
        smp = sda_i;
        wait_clk(Q);
        scl_m = 1'b0; wait_clk(Q);
    endtask

    task automatic xfer_byte(input logic [7:0] tx, input logic ack_tx, input int glitch_bit,
                             output logic [7:0] rx, output logic ack_rx);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            bit_cycle(tx[i], (glitch_bit == i), b);
            rx[i] = b;
        end
        bit_cycle(ack_tx, 1'b0, ack_rx);
    endtask

    task automatic send(input logic [7:0] d, input logic exp_ack, input string nm);
        logic [7:0] rx;
        logic       ack;
        xfer_byte(d, 1'b1, -1, rx, ack);
        chk(nm, 16'(ack), 16'(exp_ack));
    endtask

    task automatic recv(input logic [7:0] exp_d, input logic m_ack, input string nm);
        logic [7:0] rx;
        logic       ack;
        xfer_byte(8'hFF, m_ack, -1, rx, ack);
        chk(nm, 16'(rx), 16'(exp_d));
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h20] = 8'h5A;
        mem[8'h21] = 8'hC3;
        mem[8'h40] = 8'h3C;

        // Reset values
        reset_n = 1'b0;
        wait_clk(4);
        chk("rst sda_enable", 16'(sda_enable), 16'h0);
        chk("rst busy",       16'(busy),       16'h0);
        chk("rst reg_addr",   16'(reg_addr),   16'h00);
        chk("rst wr_data",    16'(wr_data),    16'h00);
        chk("rst strobes",    16'({wr_strobe, rd_strobe}), 16'h0);
        reset_n = 1'b1;
        wait_clk(Q);

        // Write transfer
        exp_wr.push_back(16'h10AB);
        exp_wr.push_back(16'h11CD);
        i2c_start();
        chk("busy after start", 16'(busy), 16'h1);
        send(8'hA0, 1'b0, "wr addr ack");
        send(8'h10, 1'b0, "wr ptr ack");
        send(8'hAB, 1'b0, "wr data0 ack");
        send(8'hCD, 1'b0, "wr data1 ack");
        i2c_stop();
        chk("busy after stop", 16'(busy), 16'h0);
        chk("wr final reg_addr", 16'(reg_addr), 16'h12);

        // Read transfer with repeated START
        exp_rd.push_back(8'h20);
        exp_rd.push_back(8'h21);
        i2c_start();
        send(8'hA0, 1'b0, "rd addr_w ack");
        send(8'h20, 1'b0, "rd ptr ack");
        i2c_start();
        send(8'hA1, 1'b0, "rd addr_r ack");
        recv(8'h5A, 1'b0, "rd byte0");
        recv(8'hC3, 1'b1, "rd byte1");
        chk("sda released after nack", 16'(sda_enable), 16'h0);
        i2c_stop();
        chk("rd final reg_addr", 16'(reg_addr), 16'h22);

        // Address mismatch, then a matching repeated START
        sda_hi_cnt = 0;
        i2c_start();
        send(8'hA2, 1'b1, "mismatch addr nack");
        send(8'h55, 1'b1, "mismatch data nack");
        chk("mismatch sda_enable never high", 16'(sda_hi_cnt), 16'h0);
        i2c_start();
        send(8'hA0, 1'b0, "after mismatch ack");
        i2c_stop();

        // Pointer wrap-around
        exp_wr.push_back(16'hFF11);
        exp_wr.push_back(16'h0022);
        i2c_start();
        send(8'hA0, 1'b0, "wrap addr ack");
        send(8'hFF, 1'b0, "wrap ptr ack");
        send(8'h11, 1'b0, "wrap data0 ack");
        send(8'h22, 1'b0, "wrap data1 ack");
        i2c_stop();
        chk("wrap final reg_addr", 16'(reg_addr), 16'h01);

        // Reset while driving a 0 data bit
        exp_rd.push_back(8'h40);
        i2c_start();
        send(8'hA0, 1'b0, "rstrd addr_w ack");
        send(8'h40, 1'b0, "rstrd ptr ack");
        i2c_start();
        send(8'hA1, 1'b0, "rstrd addr_r ack");
        chk("rstrd driving bit7=0", 16'(sda_enable), 16'h1);
        #2 reset_n = 1'b0;
        #1;
        chk("rstrd sda_enable async", 16'(sda_enable), 16'h0);
        chk("rstrd busy async", 16'(busy), 16'h0);
        wait_clk(3);
        reset_n = 1'b1;
        scl_m = 1'b1;
        sda_m = 1'b1;
        wait_clk(2*Q);
        chk("rstrd reg_addr cleared", 16'(reg_addr), 16'h00);
        i2c_start();
        send(8'hA0, 1'b0, "after reset ack");
        i2c_stop();

`ifdef I2C_TARGET_FILTER_EN
        // SCL glitch in the middle of a data byte
        begin
            logic [7:0] rx;
            logic       ack;
            exp_wr.push_back(16'h5096);
            i2c_start();
            send(8'hA0, 1'b0, "glitch addr ack");
            send(8'h50, 1'b0, "glitch ptr ack");
            xfer_byte(8'h96, 1'b1, 4, rx, ack);
            chk("glitch data ack", 16'(ack), 16'h0);
            i2c_stop();
            chk("glitch final reg_addr", 16'(reg_addr), 16'h51);
        end
`endif

        wait_clk(Q);
        chk("wr scoreboard drained", 16'(exp_wr.size()), 16'h0);
        chk("rd scoreboard drained", 16'(exp_rd.size()), 16'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
